// File: rtl/button_pkg.sv
// Shared types and default timing for the button conditioner.
// Defaults assume a 12 MHz clock.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESSED_SHORT,
    PRESSED_LONG
  } button_state_t;

  localparam int DEF_DEBOUNCE_CYCLES   = 120_000;
  localparam int DEF_LONG_PRESS_CYCLES = 12_000_000;

endpackage

// File: rtl/debouncer.sv
// Single button channel: synchronizer, debounce counter,
// edge pulses and long-press FSM.
module debouncer
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic pressed,
  output logic released,
  output logic long_press
);

  localparam int CW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(LONG_PRESS_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] stab_cnt;
  logic [CW-1:0] hold_cnt;
  logic          level_d;
  logic          differ;
  logic          toggle;
  logic          rise;
  logic          fall;
  logic          long_next;
  button_state_t state;
  button_state_t state_next;

  assign differ = sync[1] != level;
  assign toggle = differ && (stab_cnt == DB_LAST);
  assign rise   = toggle && !level;
  assign fall   = toggle && level;

  // Synchronize the raw input and accept a level change once stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      stab_cnt <= '0;
      level    <= 1'b0;
    end else begin
      sync <= {sync[0], button};
      if (!differ) begin
        stab_cnt <= '0;
      end else if (toggle) begin
        stab_cnt <= '0;
        level    <= ~level;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

  // Registered edge pulses, high the cycle after level toggles.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d  <= 1'b0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      level_d  <= level;
      pressed  <= level && !level_d;
      released <= !level && level_d;
    end
  end

  // Long-press next-state logic; a fall always wins over expiry.
  always_comb begin
    state_next = state;
    long_next  = 1'b0;
    unique case (state)
      RELEASED: begin
        if (rise) state_next = PRESSED_SHORT;
      end
      PRESSED_SHORT: begin
        if (fall) begin
          state_next = RELEASED;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = PRESSED_LONG;
          long_next  = 1'b1;
        end
      end
      PRESSED_LONG: begin
        if (fall) state_next = RELEASED;
      end
      default: state_next = RELEASED;
    endcase
  end

  // State register, saturating hold counter and long-press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RELEASED;
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      state      <= state_next;
      long_press <= long_next;
      if (state != PRESSED_SHORT) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// N independent debounced button channels with press,
// release and long-press pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BUTTONS         = 2,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] buttons,
  output logic [N_BUTTONS-1:0] level,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] released,
  output logic [N_BUTTONS-1:0] long_press
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    debouncer #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .button    (buttons[i]),
      .level     (level[i]),
      .pressed   (pressed[i]),
      .released  (released[i]),
      .long_press(long_press[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing:
// a cycle table plus hand sequences for glitch/long/reset.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] buttons;
  logic [1:0] level;
  logic [1:0] pressed;
  logic [1:0] released;
  logic [1:0] long_press;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BUTTONS        (2),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .buttons   (buttons),
    .level     (level),
    .pressed   (pressed),
    .released  (released),
    .long_press(long_press)
  );

  typedef struct {
    logic       rst;
    logic [1:0] b;
    logic [1:0] lv;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lp;
  } vec_t;

  vec_t tbl[18];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int np[2];
  int nr[2];
  int nl[2];
  int rise_cyc[2];
  int long_cyc[2];
  logic [1:0] prev_level;
  logic [1:0] any_level;

  task automatic check(input string name,
                       input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      np[i] = 0;
      nr[i] = 0;
      nl[i] = 0;
      rise_cyc[i] = -1;
      long_cyc[i] = -1;
    end
    any_level = 2'b00;
  endtask

  task automatic tick(input logic r, input logic [1:0] b);
    @(negedge clk);
    rst     = r;
    buttons = b;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (pressed[i] === 1'b1) np[i]++;
      if (released[i] === 1'b1) nr[i]++;
      if (long_press[i] === 1'b1) begin
        nl[i]++;
        long_cyc[i] = cyc;
      end
      if (level[i] === 1'b1 && prev_level[i] !== 1'b1)
        rise_cyc[i] = cyc;
      if (level[i] === 1'b1) any_level[i] = 1'b1;
    end
    prev_level = level;
  endtask

  task automatic reset_dut();
    tick(1'b1, 2'b00);
    tick(1'b1, 2'b00);
    clear_stats();
  endtask

  initial begin
    int c0;
    logic [7:0] got;
    logic [7:0] exp;
    rst        = 1'b1;
    buttons    = 2'b00;
    prev_level = 2'b00;
    clear_stats();

    tbl[0] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[1] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 2; i <= 6; i++)
      tbl[i] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[7] = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[8] = '{1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    tbl[9] = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    for (int i = 10; i <= 14; i++)
      tbl[i] = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[15] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[16] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
    tbl[17] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    // Reset with both held, simultaneous press, then release.
    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].rst, tbl[i].b);
      got = {level, pressed, released, long_press};
      exp = {tbl[i].lv, tbl[i].pr, tbl[i].rl, tbl[i].lp};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL table row %0d: got %b expected %b",
                 i, got, exp);
      end
    end

    // Three-cycle glitch on channel 1 is rejected.
    reset_dut();
    for (int i = 0; i < 3; i++) tick(1'b0, 2'b10);
    for (int i = 0; i < 10; i++) tick(1'b0, 2'b00);
    check("glitch level1", int'(any_level[1]), 0);
    check("glitch pressed1", np[1], 0);
    check("glitch released1", nr[1], 0);

    // Long hold on channel 0: one long pulse 10 after rise.
    reset_dut();
    for (int i = 0; i < 50; i++) tick(1'b0, 2'b01);
    check("long pressed0", np[0], 1);
    check("long count0", nl[0], 1);
    check("long delay0", long_cyc[0] - rise_cyc[0], 10);
    for (int i = 0; i < 10; i++) tick(1'b0, 2'b00);
    check("long released0", nr[0], 1);
    check("long count after rel", nl[0], 1);
    check("long chan1 quiet", np[1] + nl[1], 0);

    // Short press: released only, no long press.
    reset_dut();
    for (int i = 0; i < 8; i++) tick(1'b0, 2'b01);
    for (int i = 0; i < 15; i++) tick(1'b0, 2'b00);
    check("short pressed0", np[0], 1);
    check("short released0", nr[0], 1);
    check("short long0", nl[0], 0);
    check("short level end", int'(level[0]), 0);

    // Reset mid-press: silent drop, full-latency re-accept.
    reset_dut();
    for (int i = 0; i < 10; i++) tick(1'b0, 2'b01);
    check("pre-rst level0", int'(level[0]), 1);
    tick(1'b1, 2'b01);
    check("rst level0", int'(level[0]), 0);
    check("rst pulses", int'({pressed, released, long_press}), 0);
    c0 = cyc + 1;
    rise_cyc[0] = -1;
    for (int i = 0; i < 8; i++) tick(1'b0, 2'b01);
    check("rerise delay", rise_cyc[0] - c0, 5);
    check("rst no released", nr[0], 0);
    check("rerise pressed", np[0], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
